// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: widths, FSM state encodings and
// the control bundle passed from the fetch FSM to its hold buffer.
package fetch_unit_pkg;

    localparam int DATA_BITS   = 8;
    localparam int MEMORY_SIZE = 1 << DATA_BITS;

    typedef enum logic [1:0] {
        FETCH_BOOT   = 2'd0,
        FETCH_RUN    = 2'd1,
        FETCH_HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic capture;
        logic clear;
    } hold_ctrl_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// Holds the instruction presented to decode while decode stalls, so the
// memory can keep reading without losing the instruction already shown.
module fetch_hold_buffer
    import fetch_unit_pkg::*;
#(
    parameter int BITS = DATA_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  hold_ctrl_t      ctrl,
    input  logic [BITS-1:0] instruction_in,
    output logic            hold_valid,
    output logic [BITS-1:0] hold_instr,
    output logic [BITS-1:0] instr_sel
);

    logic            hold_valid_q, hold_valid_d;
    logic [BITS-1:0] hold_instr_q, hold_instr_d;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        if (ctrl.clear) begin
            hold_valid_d = 1'b0;
        end else if (ctrl.capture && !hold_valid_q) begin
            // Only the first stalled cycle captures; later reads are stale.
            hold_valid_d = 1'b1;
            hold_instr_d = instruction_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign hold_valid = hold_valid_q;
    assign hold_instr = hold_instr_q;
    assign instr_sel  = hold_valid_q ? hold_instr_q : instruction_in;

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch stage feeding decode from a registered-read
// instruction memory, with stall hold, one-bubble branch redirect and halt.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              BITS     = DATA_BITS,
    parameter logic [BITS-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [BITS-1:0] pc,
    input  logic [BITS-1:0] instruction_in,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [BITS-1:0] branch_target,
    input  logic            halt,
    output logic [BITS-1:0] instr_out,
    output logic [BITS-1:0] instr_pc,
    output logic            instr_valid
);

    fetch_state_e    state_q, state_d;
    logic [BITS-1:0] read_pc_q, read_pc_d;
    logic [BITS-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;

    hold_ctrl_t      hold_ctrl;
    logic            hold_valid;
    logic [BITS-1:0] hold_instr;
    logic [BITS-1:0] instr_sel;
    logic            run_valid;
    logic            accept;

    fetch_hold_buffer #(
        .BITS(BITS)
    ) u_hold (
        .clk           (clk),
        .rst           (rst),
        .ctrl          (hold_ctrl),
        .instruction_in(instruction_in),
        .hold_valid    (hold_valid),
        .hold_instr    (hold_instr),
        .instr_sel     (instr_sel)
    );

    assign run_valid = (state_q == FETCH_RUN) && (inflight_q || hold_valid);
    assign accept    = run_valid && !stall;

    always_comb begin
        state_d           = state_q;
        read_pc_d         = read_pc_q;
        inflight_pc_d     = inflight_pc_q;
        inflight_d        = inflight_q;
        hold_ctrl.capture = 1'b0;
        hold_ctrl.clear   = 1'b0;

        case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_RUN;
                if (branch_taken) begin
                    read_pc_d       = branch_target;
                    inflight_d      = 1'b0;
                    hold_ctrl.clear = 1'b1;
                end else begin
                    inflight_pc_d = read_pc_q;
                    read_pc_d     = read_pc_q + BITS'(1);
                    inflight_d    = 1'b1;
                end
            end

            FETCH_RUN: begin
                if (halt && accept) begin
                    state_d         = FETCH_HALTED;
                    inflight_d      = 1'b0;
                    hold_ctrl.clear = 1'b1;
                end else if (branch_taken) begin
                    // The read already in flight is from the old path; drop it.
                    read_pc_d       = branch_target;
                    inflight_d      = 1'b0;
                    hold_ctrl.clear = 1'b1;
                end else if (stall && run_valid) begin
                    hold_ctrl.capture = 1'b1;
                end else begin
                    inflight_pc_d   = read_pc_q;
                    read_pc_d       = read_pc_q + BITS'(1);
                    inflight_d      = 1'b1;
                    hold_ctrl.clear = 1'b1;
                end
            end

            FETCH_HALTED: begin
                state_d = FETCH_HALTED;
            end

            default: begin
                state_d = FETCH_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH_BOOT;
            read_pc_q     <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            read_pc_q     <= read_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    assign pc          = read_pc_q;
    assign instr_pc    = inflight_pc_q;
    assign instr_valid = run_valid;
    assign instr_out   = run_valid ? instr_sel : '0;

endmodule
